// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven 16-bit level accumulator; env_out is the upper byte.
// Optional exponential release when ADSR_EXP_RELEASE_EN is defined (default: linear release).
module adsr_envelope #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       gate,
  input  logic [7:0] attack_rate,
  input  logic [7:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_rate,
  output logic [7:0] env_out,
  output logic       env_active,
  output logic [2:0] env_state
);

  localparam int unsigned ACC_W = 16;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned PRE_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [PRE_W-1:0] presc_q;
  logic             gate_q;

  logic             rise;
  logic             tick;
  logic             release_req;
  logic [ACC_W-1:0] tgt;
  logic [SUM_W-1:0] atk_sum;
  logic [SUM_W-1:0] dec_lim;
  logic [ACC_W-1:0] rel_step;
  logic             atk_done;
  logic             dec_done;
  logic             rel_done;
`ifdef ADSR_EXP_RELEASE_EN
  logic [7:0]       sub_q;
`endif

  // Step arithmetic and end-of-segment tests, all in 17 bits so nothing wraps
  always_comb begin
    rise        = gate & ~gate_q;
    tick        = (presc_q == PRE_W'(PRESCALE - 1));
    release_req = ~gate & ((state_q == ATTACK) | (state_q == DECAY) | (state_q == SUSTAIN));
    tgt         = {sustain_level, 8'h00};
    atk_sum     = SUM_W'(acc_q) + SUM_W'(attack_rate) + SUM_W'(1);
    atk_done    = (atk_sum >= SUM_W'(16'hFFFF));
    dec_lim     = SUM_W'(tgt) + SUM_W'(decay_rate) + SUM_W'(1);
    dec_done    = (SUM_W'(acc_q) <= dec_lim);
`ifdef ADSR_EXP_RELEASE_EN
    rel_step    = (acc_q >> 4) + ACC_W'(1);
`else
    rel_step    = ACC_W'(release_rate) + ACC_W'(1);
`endif
    rel_done    = (acc_q <= rel_step);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q  <= 1'b0;
      presc_q <= '0;
      state_q <= IDLE;
      acc_q   <= '0;
`ifdef ADSR_EXP_RELEASE_EN
      sub_q   <= '0;
`endif
    end else begin
      gate_q <= gate;
      if (enable) begin
        presc_q <= tick ? '0 : presc_q + PRE_W'(1);
        // Retrigger keeps the current level; a gate drop wins over any pending step
        if (rise) begin
          state_q <= ATTACK;
        end else if (release_req) begin
          state_q <= RELEASE;
`ifdef ADSR_EXP_RELEASE_EN
          sub_q   <= '0;
`endif
        end else begin
          case (state_q)
            IDLE: acc_q <= '0;
            ATTACK: begin
              if (tick) begin
                if (atk_done) begin
                  acc_q   <= '1;
                  state_q <= DECAY;
                end else begin
                  acc_q <= atk_sum[ACC_W-1:0];
                end
              end
            end
            DECAY: begin
              if (tick) begin
                if (dec_done) begin
                  acc_q   <= tgt;
                  state_q <= SUSTAIN;
                end else begin
                  acc_q <= acc_q - ACC_W'(decay_rate) - ACC_W'(1);
                end
              end
            end
            SUSTAIN: acc_q <= tgt;
            RELEASE: begin
`ifdef ADSR_EXP_RELEASE_EN
              // Exponential curve: one proportional step every release_rate+1 ticks
              if (tick) begin
                if (sub_q == release_rate) begin
                  sub_q <= '0;
                  if (rel_done) begin
                    acc_q   <= '0;
                    state_q <= IDLE;
                  end else begin
                    acc_q <= acc_q - rel_step;
                  end
                end else begin
                  sub_q <= sub_q + 8'(1);
                end
              end
`else
              if (tick) begin
                if (rel_done) begin
                  acc_q   <= '0;
                  state_q <= IDLE;
                end else begin
                  acc_q <= acc_q - rel_step;
                end
              end
`endif
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign env_out    = acc_q[ACC_W-1:ACC_W-8];
  assign env_state  = state_q;
  assign env_active = (state_q != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: two instances (PRESCALE=1 and 4) on shared stimulus,
// a behavioural model per instance, a directed table, hand sequences and a random phase.
module tb_adsr_envelope;

  localparam int S_IDLE = 0;
  localparam int S_ATT  = 1;
  localparam int S_DEC  = 2;
  localparam int S_SUS  = 3;
  localparam int S_REL  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       gate;
  logic [7:0] atk;
  logic [7:0] dec;
  logic [7:0] sus;
  logic [7:0] rel;
  logic [7:0] o1, o4;
  logic       a1, a4;
  logic [2:0] s1, s4;

  int total = 0;
  int bad   = 0;

  adsr_envelope #(.PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .enable(enable), .gate(gate),
    .attack_rate(atk), .decay_rate(dec), .sustain_level(sus), .release_rate(rel),
    .env_out(o1), .env_active(a1), .env_state(s1)
  );

  adsr_envelope #(.PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst), .enable(enable), .gate(gate),
    .attack_rate(atk), .decay_rate(dec), .sustain_level(sus), .release_rate(rel),
    .env_out(o4), .env_active(a4), .env_state(s4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int st;
    int presc;
    bit gate_d;
    int sub;
  } mdl_t;

  typedef struct {
    bit         g;
    logic [7:0] sv;
    int         n;
    logic [7:0] e_out;
    logic [2:0] e_st;
  } vec_t;

  mdl_t m1, m4;

  // Envelope rules as plain integer arithmetic on the current inputs
  function automatic mdl_t mdl_next(input mdl_t m, input int pre);
    mdl_t n;
    bit   rise;
    bit   tick;
    int   tgt;
    int   step;
    n = m;
    if (rst) begin
      n.acc = 0; n.st = S_IDLE; n.presc = 0; n.gate_d = 1'b0; n.sub = 0;
      return n;
    end
    n.gate_d = gate;
    if (!enable) return n;
    rise    = gate && !m.gate_d;
    tick    = (m.presc == pre - 1);
    n.presc = tick ? 0 : m.presc + 1;
    tgt     = int'(sus) * 256;
    if (rise) begin
      n.st = S_ATT;
    end else if (!gate && (m.st == S_ATT || m.st == S_DEC || m.st == S_SUS)) begin
      n.st  = S_REL;
      n.sub = 0;
    end else if (m.st == S_SUS) begin
      n.acc = tgt;
    end else if (tick && m.st == S_ATT) begin
      if (m.acc + int'(atk) + 1 >= 65535) begin n.acc = 65535; n.st = S_DEC; end
      else n.acc = m.acc + int'(atk) + 1;
    end else if (tick && m.st == S_DEC) begin
      if (m.acc - (int'(dec) + 1) <= tgt) begin n.acc = tgt; n.st = S_SUS; end
      else n.acc = m.acc - (int'(dec) + 1);
    end else if (tick && m.st == S_REL) begin
`ifdef ADSR_EXP_RELEASE_EN
      if (m.sub == int'(rel)) begin
        n.sub = 0;
        step  = m.acc / 16 + 1;
        if (m.acc <= step) begin n.acc = 0; n.st = S_IDLE; end
        else n.acc = m.acc - step;
      end else begin
        n.sub = m.sub + 1;
      end
`else
      step = int'(rel) + 1;
      if (m.acc <= step) begin n.acc = 0; n.st = S_IDLE; end
      else n.acc = m.acc - step;
`endif
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // One clock: advance both models, then compare both instances
  task automatic step_clk();
    @(posedge clk);
    m1 = mdl_next(m1, 1);
    m4 = mdl_next(m4, 4);
    #1;
    chk("p1_out",    32'(o1), 32'(m1.acc >> 8));
    chk("p1_state",  32'(s1), 32'(m1.st));
    chk("p1_active", 32'(a1), 32'(m1.st != S_IDLE));
    chk("p4_out",    32'(o4), 32'(m4.acc >> 8));
    chk("p4_state",  32'(s4), 32'(m4.st));
    chk("p4_active", 32'(a4), 32'(m4.st != S_IDLE));
  endtask

  task automatic run(input int n);
    repeat (n) step_clk();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
  endtask

`ifdef ADSR_EXP_RELEASE_EN
  localparam int NROWS = 9;
`else
  localparam int NROWS = 11;
`endif

  initial begin
    vec_t tbl[11];
    logic [31:0] prev;
    bit found;

    tbl[0]  = '{g:1'b0, sv:8'h80, n:2,    e_out:8'h00, e_st:3'd0};
    tbl[1]  = '{g:1'b1, sv:8'h80, n:1,    e_out:8'h00, e_st:3'd1};
    tbl[2]  = '{g:1'b1, sv:8'h80, n:255,  e_out:8'hFF, e_st:3'd1};
    tbl[3]  = '{g:1'b1, sv:8'h80, n:1,    e_out:8'hFF, e_st:3'd2};
    tbl[4]  = '{g:1'b1, sv:8'h80, n:127,  e_out:8'h80, e_st:3'd2};
    tbl[5]  = '{g:1'b1, sv:8'h80, n:1,    e_out:8'h80, e_st:3'd3};
    tbl[6]  = '{g:1'b1, sv:8'h60, n:1,    e_out:8'h60, e_st:3'd3};
    tbl[7]  = '{g:1'b1, sv:8'h80, n:1,    e_out:8'h80, e_st:3'd3};
    tbl[8]  = '{g:1'b0, sv:8'h80, n:1,    e_out:8'h80, e_st:3'd4};
    tbl[9]  = '{g:1'b0, sv:8'h80, n:2047, e_out:8'h00, e_st:3'd4};
    tbl[10] = '{g:1'b0, sv:8'h80, n:1,    e_out:8'h00, e_st:3'd0};

    m1 = '{acc:0, st:0, presc:0, gate_d:1'b0, sub:0};
    m4 = m1;
    rst = 1'b1; enable = 1'b1; gate = 1'b0;
    atk = 8'hFF; dec = 8'hFF; sus = 8'h80; rel = 8'h0F;

    // Reset state
    run(2);
    chk("rst_out1",   32'(o1), 32'h0);
    chk("rst_state1", 32'(s1), 32'h0);
    chk("rst_act1",   32'(a1), 32'h0);
    chk("rst_out4",   32'(o4), 32'h0);
    rst = 1'b0;

    // T1: full linear cycle on the PRESCALE=1 instance
    for (int r = 0; r < NROWS; r++) begin
      gate = tbl[r].g;
      sus  = tbl[r].sv;
      run(tbl[r].n);
      chk($sformatf("T1_row%0d_out", r),   32'(o1), 32'(tbl[r].e_out));
      chk($sformatf("T1_row%0d_state", r), 32'(s1), 32'(tbl[r].e_st));
      chk($sformatf("T1_row%0d_act", r),   32'(a1), 32'(tbl[r].e_st != 3'd0));
    end

    // T2: reset mid-attack with gate held high
    do_reset();
    gate = 1'b0; run(1);
    gate = 1'b1; run(1);
    run(64);
    chk("T2_pre_out", 32'(o1), 32'h40);
    rst = 1'b1; step_clk(); rst = 1'b0;
    chk("T2_rst_out",   32'(o1), 32'h0);
    chk("T2_rst_state", 32'(s1), 32'h0);
    chk("T2_rst_act",   32'(a1), 32'h0);
    run(1);
    chk("T2_rise_state", 32'(s1), 32'd1);
    chk("T2_rise_out",   32'(o1), 32'h0);

    // T3: retrigger during release at level 0x40
    run(256 + 128);
    chk("T3_sus_out",   32'(o1), 32'h80);
    chk("T3_sus_state", 32'(s1), 32'd3);
`ifndef ADSR_EXP_RELEASE_EN
    rel = 8'hFF; gate = 1'b0; run(1);
    run(64);
    chk("T3_rel_out",   32'(o1), 32'h40);
    chk("T3_rel_state", 32'(s1), 32'd4);
    gate = 1'b1; run(1);
    chk("T3_retrig_state", 32'(s1), 32'd1);
    chk("T3_retrig_out",   32'(o1), 32'h40);
    run(1);
    chk("T3_climb_out", 32'(o1), 32'h41);
`endif

    // T4: gate fall coinciding with a tick in DECAY (PRESCALE=4)
    do_reset();
    atk = 8'hFF; dec = 8'hFF; sus = 8'h80; rel = 8'hFF;
    gate = 1'b0; run(1);
    gate = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step_clk();
      found = (m4.st == S_DEC) && (m4.presc == 3);
    end
    chk("T4_in_decay", 32'(s4), 32'd2);
    prev = 32'(m4.acc >> 8);
    gate = 1'b0; run(1);
    chk("T4_hold_out", 32'(o4), prev);
    chk("T4_state",    32'(s4), 32'd4);
    run(3);
    chk("T4_wait_out", 32'(o4), prev);
`ifndef ADSR_EXP_RELEASE_EN
    run(1);
    chk("T4_step_out", 32'(o4), prev - 32'd1);
`endif

    // T5: enable low for 100 cycles mid-attack, rise while disabled is lost
    do_reset();
    atk = 8'hFF; gate = 1'b0; run(1);
    gate = 1'b1; run(1);
    run(64);
    chk("T5_pre_out", 32'(o1), 32'h40);
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      gate = (i >= 30 && i < 60) ? 1'b0 : 1'b1;
      step_clk();
      chk("T5_frz_out",   32'(o1), 32'h40);
      chk("T5_frz_state", 32'(s1), 32'd1);
    end
    enable = 1'b1; gate = 1'b1; run(1);
    chk("T5_resume_out",   32'(o1), 32'h41);
    chk("T5_resume_state", 32'(s1), 32'd1);

`ifdef ADSR_EXP_RELEASE_EN
    // T6: exponential release from 0x8000 with release_rate 0
    do_reset();
    atk = 8'hFF; dec = 8'hFF; sus = 8'h80; rel = 8'h00;
    gate = 1'b0; run(1);
    gate = 1'b1; run(1);
    run(256 + 128);
    chk("T6_sus_out", 32'(o1), 32'h80);
    gate = 1'b0; run(1);
    run(1);
    chk("T6_first_out", 32'(o1), 32'h77);
    for (int i = 0; i < 2000 && m1.st != S_IDLE; i++) run(1);
    chk("T6_idle_state", 32'(s1), 32'd0);
    chk("T6_idle_out",   32'(o1), 32'h0);
`endif

    // Random phase against the models
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 199) == 0) gate = ~gate;
      if ($urandom_range(0, 299) == 0) atk = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) dec = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) == 0)  sus = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) rel = 8'($urandom_range(0, 255));
      step_clk();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
